// File: rtl/fb_write_queue.sv
// Framebuffer write queue: buffers voxel-engine writes and drains them to the RAM port only while display_on is low.
// Optional in-place coalescing of back-to-back writes to the same address when FB_WRITE_COALESCE_EN is defined.
module fb_write_queue #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  display_on,
  input  logic                  clear,
  input  logic                  clr_ovf,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_d,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);

  localparam int unsigned         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                  state, state_next;
  logic [ADDR_W-1:0]       mem_addr [DEPTH];
  logic [DATA_W-1:0]       mem_data [DEPTH];
  logic [DEPTH_LOG2-1:0]   wptr, rptr;
  logic [DEPTH_LOG2:0]     count, count_next;
  logic                    is_full, is_empty;
  logic                    pop, push, drop, coalesce;

  assign is_full  = (count == CNT_FULL);
  assign is_empty = (count == '0);
  assign full     = is_full;
  assign empty    = is_empty;
  assign level    = count;

`ifdef FB_WRITE_COALESCE_EN
  logic [DEPTH_LOG2-1:0] last_ptr;
  assign last_ptr = wptr - PTR_ONE;
  // A match on the entry leaving this cycle falls back to an ordinary push.
  assign coalesce = wr_en && !is_empty && (mem_addr[last_ptr] == wr_addr) &&
                    !(pop && (rptr == last_ptr));
`else
  assign coalesce = 1'b0;
`endif

  assign push = wr_en && !is_full && !coalesce && !clear;
  assign drop = wr_en && is_full && !coalesce;

  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_next = count + CNT_ONE;
        2'b01:   count_next = count - CNT_ONE;
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (!display_on && !is_empty) state_next = DRAIN;
        DRAIN: if (display_on || count_next == '0) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    pop = (state == DRAIN) && !is_empty && !display_on && !clear;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_d    <= '0;
      overflow <= 1'b0;
    end else begin
      count  <= count_next;
      ram_we <= pop;
      if (clear) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) wptr <= wptr + PTR_ONE;
        if (pop)  rptr <= rptr + PTR_ONE;
      end
      if (pop) begin
        ram_addr <= mem_addr[rptr];
        ram_d    <= mem_data[rptr];
      end
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wptr] <= wr_addr;
      mem_data[wptr] <= wr_data;
    end
`ifdef FB_WRITE_COALESCE_EN
    else if (coalesce) begin
      mem_data[last_ptr] <= wr_data;
    end
`endif
  end

endmodule

// File: tb/tb_fb_write_queue.sv
// Self-checking bench for fb_write_queue: vector table, directed corner sequences and a randomized queue-model run.
module tb_fb_write_queue;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int DL = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          display_on;
  logic          clear;
  logic          clr_ovf;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_d;
  logic          full;
  logic          empty;
  logic [DL:0]   level;
  logic          overflow;

  always #5 clk = ~clk;

  fb_write_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .display_on(display_on), .clear(clear), .clr_ovf(clr_ovf), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_d(ram_d), .full(full), .empty(empty), .level(level),
    .overflow(overflow)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; clear = 1'b0; clr_ovf = 1'b0;
  endtask

  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          dis;
    logic          exp_we;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    logic [DL:0]   exp_lvl;
  } vec_t;

  vec_t tbl [19];

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  bit            m_drn;
  bit            m_ovf;
  logic          m_we;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d;

  task automatic model_reset();
    q.delete(); m_drn = 0; m_ovf = 0; m_we = 0; m_a = '0; m_d = '0;
  endtask

  // Queue-level model: applies one clock edge given the inputs sampled on it.
  task automatic model_step(input bit wen, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                            input bit dis, input bit clr, input bit cov);
    int   sz;
    bit   fullm, pop_m, coal, drp;
    ent_t e;
    sz    = q.size();
    fullm = (sz == 16);
    pop_m = m_drn && sz > 0 && !dis && !clr;
    coal  = 0;
`ifdef FB_WRITE_COALESCE_EN
    coal  = wen && sz > 0 && q[sz-1].a == wa && !(pop_m && sz == 1);
`endif
    drp = wen && fullm && !coal;
    if (drp) m_ovf = 1;
    else if (cov) m_ovf = 0;
    if (clr) begin
      q.delete(); m_drn = 0; m_we = 0;
    end else begin
      m_we = pop_m;
      if (pop_m) begin
        e = q.pop_front(); m_a = e.a; m_d = e.d;
      end
      if (coal) q[q.size()-1].d = wd;
      else if (wen && !fullm) q.push_back('{a: wa, d: wd});
      if (!m_drn) m_drn = !dis && sz > 0;
      else        m_drn = !dis && q.size() > 0;
    end
  endtask

  initial begin
    int           got;
    logic [DW-1:0] seen_d [4];
    quiet();
    display_on = 1'b0;
    reset_n    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_we_in", ram_we, 0);
    reset_n = 1'b1;
    check("rst_we", ram_we, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_d", ram_d, 0);
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);

    tbl[0]  = '{1, 12'h010, 8'hFF, 0, 0, 12'h000, 8'h00, 5'd1};
    tbl[1]  = '{0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 5'd1};
    tbl[2]  = '{0, 12'h000, 8'h00, 0, 1, 12'h010, 8'hFF, 5'd0};
    tbl[3]  = '{0, 12'h000, 8'h00, 0, 0, 12'h010, 8'hFF, 5'd0};
    tbl[4]  = '{1, 12'h100, 8'hA0, 1, 0, 12'h010, 8'hFF, 5'd1};
    tbl[5]  = '{1, 12'h101, 8'hA1, 1, 0, 12'h010, 8'hFF, 5'd2};
    tbl[6]  = '{1, 12'h102, 8'hA2, 1, 0, 12'h010, 8'hFF, 5'd3};
    tbl[7]  = '{1, 12'h103, 8'hA3, 1, 0, 12'h010, 8'hFF, 5'd4};
    tbl[8]  = '{1, 12'h104, 8'hA4, 1, 0, 12'h010, 8'hFF, 5'd5};
    tbl[9]  = '{0, 12'h000, 8'h00, 0, 0, 12'h010, 8'hFF, 5'd5};
    tbl[10] = '{0, 12'h000, 8'h00, 0, 1, 12'h100, 8'hA0, 5'd4};
    tbl[11] = '{0, 12'h000, 8'h00, 0, 1, 12'h101, 8'hA1, 5'd3};
    tbl[12] = '{0, 12'h000, 8'h00, 1, 0, 12'h101, 8'hA1, 5'd3};
    tbl[13] = '{0, 12'h000, 8'h00, 1, 0, 12'h101, 8'hA1, 5'd3};
    tbl[14] = '{0, 12'h000, 8'h00, 0, 0, 12'h101, 8'hA1, 5'd3};
    tbl[15] = '{0, 12'h000, 8'h00, 0, 1, 12'h102, 8'hA2, 5'd2};
    tbl[16] = '{0, 12'h000, 8'h00, 0, 1, 12'h103, 8'hA3, 5'd1};
    tbl[17] = '{0, 12'h000, 8'h00, 0, 1, 12'h104, 8'hA4, 5'd0};
    tbl[18] = '{0, 12'h000, 8'h00, 0, 0, 12'h104, 8'hA4, 5'd0};

    foreach (tbl[i]) begin
      wr_en = tbl[i].we; wr_addr = tbl[i].a; wr_data = tbl[i].d; display_on = tbl[i].dis;
      step();
      check($sformatf("tbl%0d_we", i), ram_we, tbl[i].exp_we);
      check($sformatf("tbl%0d_addr", i), ram_addr, tbl[i].exp_a);
      check($sformatf("tbl%0d_d", i), ram_d, tbl[i].exp_d);
      check($sformatf("tbl%0d_level", i), level, tbl[i].exp_lvl);
    end
    quiet();
    check("tbl_empty", empty, 1);

    // Overflow: 17 writes while scanout owns the RAM port.
    display_on = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_addr = 12'h200 + AW'(i); wr_data = DW'(i);
      step();
      if (i == 15) begin
        check("ovf_full16", full, 1);
        check("ovf_not_yet", overflow, 0);
      end
    end
    quiet();
    check("ovf_set", overflow, 1);
    check("ovf_level", level, 16);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);
    check("ovf_level_kept", level, 16);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_level", level, 0);
    check("clr_empty", empty, 1);
    display_on = 1'b0;
    repeat (4) begin
      step();
      check("clr_no_we", ram_we, 0);
    end

    // Three fill/drain rounds exercise pointer wrap.
    for (int r = 0; r < 3; r++) begin
      display_on = 1'b1;
      for (int i = 0; i < 16; i++) begin
        wr_en = 1'b1; wr_addr = 12'h300 + AW'(r*16 + i); wr_data = DW'(r*16 + i + 7);
        step();
      end
      quiet();
      check("wrap_full", full, 1);
      display_on = 1'b0;
      got = 0;
      for (int c = 0; c < 40 && got < 16; c++) begin
        step();
        if (ram_we) begin
          check("wrap_addr", ram_addr, 12'h300 + r*16 + got);
          check("wrap_data", ram_d, DW'(r*16 + got + 7));
          got++;
        end
      end
      check("wrap_count", got, 16);
      step();
      check("wrap_empty", empty, 1);
      check("wrap_we_off", ram_we, 0);
    end

    // Clear in the middle of a fill.
    display_on = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wr_en = 1'b1; wr_addr = 12'h500 + AW'(i); wr_data = DW'(i);
      step();
    end
    quiet();
    check("mid_level", level, 7);
    clear = 1'b1;
    step();
    clear = 1'b0;
    display_on = 1'b0;
    check("mid_clr_level", level, 0);
    repeat (5) begin
      step();
      check("mid_clr_no_we", ram_we, 0);
    end

    // Same-address back-to-back writes.
    display_on = 1'b1;
    wr_en = 1'b1; wr_addr = 12'h020; wr_data = 8'h11;
    step();
    wr_data = 8'h22;
    step();
    quiet();
`ifdef FB_WRITE_COALESCE_EN
    check("coal_level", level, 1);
`else
    check("coal_level", level, 2);
`endif
    display_on = 1'b0;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (ram_we) begin
        if (got < 4) seen_d[got] = ram_d;
        check("coal_addr", ram_addr, 12'h020);
        got++;
      end
    end
`ifdef FB_WRITE_COALESCE_EN
    check("coal_count", got, 1);
    check("coal_d0", seen_d[0], 8'h22);
`else
    check("coal_count", got, 2);
    check("coal_d0", seen_d[0], 8'h11);
    check("coal_d1", seen_d[1], 8'h22);
`endif

    // Randomized run against the queue model.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    display_on = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) display_on = ~display_on;
      wr_en   = ($urandom_range(0, 9) < 6);
      wr_addr = 12'h400 + AW'($urandom_range(0, 5));
      wr_data = DW'($urandom);
      clear   = ($urandom_range(0, 79) == 0);
      clr_ovf = ($urandom_range(0, 19) == 0);
      model_step(wr_en, wr_addr, wr_data, display_on, clear, clr_ovf);
      step();
      check("rnd_we", ram_we, m_we);
      check("rnd_addr", ram_addr, m_a);
      check("rnd_d", ram_d, m_d);
      check("rnd_level", level, q.size());
      check("rnd_full", full, q.size() == 16);
      check("rnd_empty", empty, q.size() == 0);
      check("rnd_ovf", overflow, m_ovf);
    end
    quiet();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_write_queue.md
Name: fb_write_queue

Overview:
- Downstream stage of the voxel projection engine. Consumes its write stream (we/addr/data), buffers the writes in a FIFO and drains them into the framebuffer RAM write port.
- Drains only while the display is blanked (display_on low), so scanout never collides with a write.
- Reports fill level and overflow back to the producer/control logic.

Parameters:
- ADDR_W, 12, framebuffer address width
- DATA_W, 8, pixel data width
- DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 16 entries)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- wr_en  in  1  write request from voxel engine
- wr_addr  in  ADDR_W  framebuffer address of request
- wr_data  in  DATA_W  pixel value of request
- display_on  in  1  high = active video; RAM port reserved for scanout
- clear  in  1  synchronous discard of all queued entries
- clr_ovf  in  1  clears sticky overflow flag
- ram_we  out  1  framebuffer write strobe (one cycle per entry)
- ram_addr  out  ADDR_W  framebuffer write address
- ram_d  out  DATA_W  framebuffer write data
- full  out  1  FIFO holds DEPTH entries
- empty  out  1  FIFO holds 0 entries
- level  out  DEPTH_LOG2+1  current entry count
- overflow  out  1  sticky: a request was dropped

Behaviour:
- Reset (reset_n low, async): ram_we=0, ram_addr=0, ram_d=0, level=0, empty=1, full=0, overflow=0, read/write pointers=0, FSM=IDLE. Asserting reset mid-drain aborts immediately; queued entries are lost.
- Storage: circular buffer of DEPTH entries {addr,data}. Pointers are DEPTH_LOG2 bits wide and wrap naturally from DEPTH-1 to 0. full/empty/level come from a registered count (0..DEPTH).
- Push: wr_en=1 and full=0 at an edge writes the entry at the write pointer, and the pointer increments.
- Overflow: wr_en=1 while full=1 drops the request and sets overflow. A pop in the same cycle does not rescue the request, because full is evaluated on the registered count.
- overflow stays set until clr_ovf=1. If clr_ovf and a dropping write occur in the same cycle, set wins.
- FSM states:
  - IDLE: ram_we=0. Go to DRAIN when display_on=0 and count>0.
  - DRAIN: each cycle with count>0 and display_on=0, pop the head entry into the output registers and assert ram_we for that cycle. Return to IDLE when count reaches 0 after a pop, or when display_on=1 is sampled. In the second case no new pop occurs; an entry already registered completes its single ram_we cycle.
- Latency: a request sampled at edge N into an empty FIFO, with display_on=0 throughout, produces ram_we=1 after edge N+2 (push at N, FSM to DRAIN at N+1, pop at N+2). Sustained drain rate is one entry per clock.
- No bypass: an entry pushed at edge N cannot pop before edge N+1.
- Simultaneous push and pop: both take effect and count is unchanged. At count=DEPTH the push is rejected (see Overflow).
- ram_addr/ram_d hold their last values when ram_we=0.
- clear=1: pointers and count go to 0, FSM goes to IDLE, ram_we=0 next cycle. clear has priority over a push or pop in the same cycle. overflow is unaffected.
- All arithmetic is unsigned. level is DEPTH_LOG2+1 bits so that DEPTH is representable.

Optional Feature:
- Macro: FB_WRITE_COALESCE_EN
- Defined:
  - Condition: wr_en=1, wr_addr equals the address of the most recently pushed entry, count>0, and that entry is not being popped in the same cycle.
  - Effect: the entry's data is overwritten in place. Count does not change, and the write is accepted even when full (no overflow).
  - A match against the entry being popped in the same cycle is treated as a normal push.
- Undefined: every accepted wr_en pushes a new entry; no address comparison logic is present.

Test Plan:
- Reset then idle: reset_n low 3 cycles, release -> all outputs 0, empty=1, level=0, FSM in IDLE.
- Basic drain: display_on=0; write addr 0x010 data 0xFF at edge 0 -> ram_we=1 with ram_addr=0x010, ram_d=0xFF after edge 2, for exactly one cycle; then empty=1.
- Blanking gate: display_on=1; push 5 entries (0x100..0x104) -> no ram_we, level=5. Drop display_on -> 5 consecutive ram_we cycles in order 0x100..0x104. Raise display_on after the 2nd -> drain stops, level=3, and the rest resume at the next blanking.
- Overflow: display_on=1; 17 writes -> full=1 after the 16th; the 17th is dropped and overflow=1. clr_ovf -> overflow=0, level still 16.
- Wrap and clear: 3 rounds of fill-16/drain-16 with distinct data -> output order and values match input. Mid-fill, clear -> level=0, no ram_we afterwards.
- Coalesce (macro defined): display_on=1; writes (0x020,0x11) then (0x020,0x22) -> level=1; after drain a single ram_we with ram_d=0x22. Without the macro -> level=2 and two writes, 0x11 then 0x22.
